// File: rtl/comp_scheduler.sv
// comp_scheduler: splits page jobs across N_CORES compression cores and
// returns completions in dispatch order.
// Optional feature macro: COMP_SCHED_STATS_EN enables the stat_pages and
// stat_bytes_out counters. Without it, both outputs are tied to zero.
module comp_scheduler #(
    parameter int N_CORES         = 6,
    parameter int PAGE_BYTES      = 8192,
    parameter int VADDR_BITS      = 48,
    parameter int PAGE_SIZE_WIDTH = $clog2(PAGE_BYTES + 1)
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               s_job_valid,
    output logic                               s_job_ready,
    input  logic [VADDR_BITS-1:0]              s_job_vaddr,
    input  logic [31:0]                        s_job_len,
    output logic [N_CORES-1:0]                 m_core_valid,
    input  logic [N_CORES-1:0]                 m_core_ready,
    output logic [VADDR_BITS-1:0]              m_core_vaddr,
    output logic [PAGE_SIZE_WIDTH-1:0]         m_core_len,
    input  logic [N_CORES-1:0]                 core_done,
    input  logic [N_CORES*PAGE_SIZE_WIDTH-1:0] core_done_size,
    output logic                               m_cpl_valid,
    input  logic                               m_cpl_ready,
    output logic [VADDR_BITS-1:0]              m_cpl_vaddr,
    output logic [PAGE_SIZE_WIDTH-1:0]         m_cpl_size,
    output logic                               m_cpl_last,
    output logic [31:0]                        stat_pages,
    output logic [47:0]                        stat_bytes_out
);

    localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int PW = PAGE_SIZE_WIDTH;
    localparam logic [CW:0]   N_WRAP      = (CW+1)'(N_CORES);
    localparam logic [CW:0]   ONE_CNT     = 1;
    localparam logic [31:0]   PAGE_LEN32  = 32'(PAGE_BYTES);
    localparam logic [PW-1:0] PAGE_LEN_PW = PW'(PAGE_BYTES);

    typedef logic [VADDR_BITS-1:0] vaddr_t;
    typedef logic [PW-1:0]         page_size_t;
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    // Increment a core index, wrapping at N_CORES.
    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        logic [CW:0] s;
        s = {1'b0, v} + ONE_CNT;
        if (s >= N_WRAP) s = '0;
        return s[CW-1:0];
    endfunction

    state_t               state_reg, state_next;
    logic                 ready_reg;
    vaddr_t               vaddr_reg, vaddr_next;
    logic [31:0]          rem_reg, rem_next;
    logic [CW-1:0]        rr_reg, rr_next;
    logic [N_CORES-1:0]   busy_reg, busy_next;
    logic [N_CORES-1:0]   core_valid_reg, core_valid_next;
    logic [CW-1:0]        disp_idx_reg, disp_idx_next;

    // Order FIFO: one entry per page in flight, never deeper than N_CORES
    // because a page only leaves when its core goes busy.
    logic [CW-1:0]        fifo_core  [N_CORES];
    vaddr_t               fifo_vaddr [N_CORES];
    logic                 fifo_last  [N_CORES];
    logic [CW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW:0]          count_reg;
    logic [CW-1:0]        head_core;

    logic                 cpl_valid_reg;
    vaddr_t               cpl_vaddr_reg;
    page_size_t           cpl_size_reg;
    logic                 cpl_last_reg;
    logic [CW-1:0]        cpl_core_reg;

    logic [N_CORES-1:0]          result_valid;
    logic [N_CORES-1:0][PW-1:0]  result_size;

    logic                 job_hs, disp_hs, cpl_hs;
    logic                 page_last;
    page_size_t           page_len;
    logic [N_CORES-1:0]   disp_mask, free_mask;
    logic                 sel_found;
    logic [CW-1:0]        sel_idx;
    logic [CW:0]          cand;

    assign job_hs    = s_job_valid && ready_reg;
    assign disp_hs   = |(core_valid_reg & m_core_ready);
    assign cpl_hs    = cpl_valid_reg && m_cpl_ready;
    assign page_last = (rem_reg <= PAGE_LEN32);
    assign page_len  = page_last ? rem_reg[PW-1:0] : PAGE_LEN_PW;
    assign head_core = fifo_core[rd_ptr_reg];

    // Per-core masks plus the result register that catches each done pulse.
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
        logic       rv_reg;
        page_size_t rs_reg;

        assign disp_mask[gi] = disp_hs && (disp_idx_reg == CW'(gi));
        assign free_mask[gi] = cpl_hs && (cpl_core_reg == CW'(gi));

        // Latch the compressed size once per busy period; stray pulses are ignored.
        always_ff @(posedge aclk) begin
            if (areset) begin
                rv_reg <= 1'b0;
                rs_reg <= '0;
            end else if (free_mask[gi]) begin
                rv_reg <= 1'b0;
            end else if (core_done[gi] && busy_reg[gi] && !rv_reg) begin
                rv_reg <= 1'b1;
                rs_reg <= core_done_size[gi*PW +: PW];
            end
        end

        assign result_valid[gi] = rv_reg;
        assign result_size[gi]  = rs_reg;
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and the job cursor (address, remaining bytes, rr, busy).
    always_comb begin
        state_next = state_reg;
        vaddr_next = vaddr_reg;
        rem_next   = rem_reg;
        rr_next    = rr_reg;
        busy_next  = (busy_reg & ~free_mask) | disp_mask;
        case (state_reg)
            IDLE: begin
                if (job_hs && (s_job_len != 32'd0)) begin
                    state_next = ISSUE;
                    vaddr_next = s_job_vaddr;
                    rem_next   = s_job_len;
                end
            end
            ISSUE: begin
                if (disp_hs) begin
                    vaddr_next = vaddr_reg + VADDR_BITS'(page_len);
                    rem_next   = rem_reg - 32'(page_len);
                    rr_next    = wrap_inc(disp_idx_reg);
                    if (page_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Round-robin search over next-cycle idle cores, so a core freed or a
    // pointer moved this cycle is already visible to the next dispatch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_CORES; k++) begin
            cand = {1'b0, rr_next} + (CW+1)'(k);
            if (cand >= N_WRAP) cand = cand - N_WRAP;
            if (!sel_found && !busy_next[cand[CW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[CW-1:0];
            end
        end
    end

    // Dispatch valid: hold while unaccepted, otherwise offer the next page.
    always_comb begin
        core_valid_next = '0;
        disp_idx_next   = disp_idx_reg;
        if ((|core_valid_reg) && !disp_hs) begin
            core_valid_next = core_valid_reg;
        end else if ((state_next == ISSUE) && sel_found) begin
            core_valid_next[sel_idx] = 1'b1;
            disp_idx_next            = sel_idx;
        end
    end

    // Job cursor, core bookkeeping and registered dispatch outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ready_reg      <= 1'b0;
            vaddr_reg      <= '0;
            rem_reg        <= '0;
            rr_reg         <= '0;
            busy_reg       <= '0;
            core_valid_reg <= '0;
            disp_idx_reg   <= '0;
        end else begin
            ready_reg      <= (state_next == IDLE);
            vaddr_reg      <= vaddr_next;
            rem_reg        <= rem_next;
            rr_reg         <= rr_next;
            busy_reg       <= busy_next;
            core_valid_reg <= core_valid_next;
            disp_idx_reg   <= disp_idx_next;
        end
    end

    // Order FIFO storage; contents are don't-care until pointers say otherwise.
    always_ff @(posedge aclk) begin
        if (disp_hs) begin
            fifo_core[wr_ptr_reg]  <= disp_idx_reg;
            fifo_vaddr[wr_ptr_reg] <= vaddr_reg;
            fifo_last[wr_ptr_reg]  <= page_last;
        end
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (disp_hs) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
            if (cpl_hs)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
            case ({disp_hs, cpl_hs})
                2'b10:   count_reg <= count_reg + ONE_CNT;
                2'b01:   count_reg <= count_reg - ONE_CNT;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Completion register: loads when the oldest page's core has reported.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cpl_valid_reg <= 1'b0;
            cpl_vaddr_reg <= '0;
            cpl_size_reg  <= '0;
            cpl_last_reg  <= 1'b0;
            cpl_core_reg  <= '0;
        end else if (cpl_hs) begin
            cpl_valid_reg <= 1'b0;
        end else if (!cpl_valid_reg && (count_reg != '0) && result_valid[head_core]) begin
            cpl_valid_reg <= 1'b1;
            cpl_vaddr_reg <= fifo_vaddr[rd_ptr_reg];
            cpl_size_reg  <= result_size[head_core];
            cpl_last_reg  <= fifo_last[rd_ptr_reg];
            cpl_core_reg  <= head_core;
        end
    end

`ifdef COMP_SCHED_STATS_EN
    logic [31:0] pages_reg;
    logic [47:0] bytes_reg;

    // Wrapping counters of dispatched pages and delivered compressed bytes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pages_reg <= '0;
            bytes_reg <= '0;
        end else begin
            if (disp_hs) pages_reg <= pages_reg + 32'd1;
            if (cpl_hs)  bytes_reg <= bytes_reg + 48'(cpl_size_reg);
        end
    end

    assign stat_pages     = pages_reg;
    assign stat_bytes_out = bytes_reg;
`else
    assign stat_pages     = '0;
    assign stat_bytes_out = '0;
`endif

    assign s_job_ready  = ready_reg;
    assign m_core_valid = core_valid_reg;
    assign m_core_vaddr = vaddr_reg;
    assign m_core_len   = page_len;
    assign m_cpl_valid  = cpl_valid_reg;
    assign m_cpl_vaddr  = cpl_vaddr_reg;
    assign m_cpl_size   = cpl_size_reg;
    assign m_cpl_last   = cpl_last_reg;

endmodule

// File: tb/tb_comp_scheduler.sv
// Directed testbench for comp_scheduler: page split, ordering, stall,
// zero-length job, mid-job reset and statistics.
module tb_comp_scheduler;

    localparam int N  = 6;
    localparam int PW = 14;
    localparam int VB = 48;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              s_job_valid = 1'b0;
    logic              s_job_ready;
    logic [VB-1:0]     s_job_vaddr = '0;
    logic [31:0]       s_job_len = '0;
    logic [N-1:0]      m_core_valid;
    logic [N-1:0]      m_core_ready = '0;
    logic [VB-1:0]     m_core_vaddr;
    logic [PW-1:0]     m_core_len;
    logic [N-1:0]      core_done = '0;
    logic [N*PW-1:0]   core_done_size = '0;
    logic              m_cpl_valid;
    logic              m_cpl_ready = 1'b0;
    logic [VB-1:0]     m_cpl_vaddr;
    logic [PW-1:0]     m_cpl_size;
    logic              m_cpl_last;
    logic [31:0]       stat_pages;
    logic [47:0]       stat_bytes_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [VB-1:0] vaddr;
        logic [PW-1:0] len;
        int            core;
    } disp_t;

    typedef struct {
        int            pre_core;   // core to pulse done before waiting, -1 for none
        int            pre_size;
        logic [VB-1:0] vaddr;
        logic [PW-1:0] size;
        logic          last;
    } cpl_t;

    disp_t disp_tab [3];
    cpl_t  cpl_tab  [3];

    comp_scheduler dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_job_valid    (s_job_valid),
        .s_job_ready    (s_job_ready),
        .s_job_vaddr    (s_job_vaddr),
        .s_job_len      (s_job_len),
        .m_core_valid   (m_core_valid),
        .m_core_ready   (m_core_ready),
        .m_core_vaddr   (m_core_vaddr),
        .m_core_len     (m_core_len),
        .core_done      (core_done),
        .core_done_size (core_done_size),
        .m_cpl_valid    (m_cpl_valid),
        .m_cpl_ready    (m_cpl_ready),
        .m_cpl_vaddr    (m_cpl_vaddr),
        .m_cpl_size     (m_cpl_size),
        .m_cpl_last     (m_cpl_last),
        .stat_pages     (stat_pages),
        .stat_bytes_out (stat_bytes_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic do_reset();
        areset         = 1'b1;
        s_job_valid    = 1'b0;
        m_core_ready   = '0;
        m_cpl_ready    = 1'b0;
        core_done      = '0;
        core_done_size = '0;
        repeat (2) @(negedge aclk);
        check("rst_job_ready",  64'(s_job_ready), 64'd0);
        check("rst_core_valid", 64'(m_core_valid), 64'd0);
        check("rst_cpl_valid",  64'(m_cpl_valid), 64'd0);
        check("rst_cpl_last",   64'(m_cpl_last), 64'd0);
        check("rst_cpl_data",   64'(m_cpl_vaddr) | 64'(m_cpl_size), 64'd0);
        check("rst_core_data",  64'(m_core_vaddr) | 64'(m_core_len), 64'd0);
        check("rst_stats",      64'(stat_pages) | 64'(stat_bytes_out), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_release_ready", 64'(s_job_ready), 64'd1);
    endtask

    task automatic send_job(input logic [VB-1:0] va, input logic [31:0] len);
        int n = 0;
        while (!s_job_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!s_job_ready) begin
            errors++;
            checks++;
            $display("FAIL job_accept_timeout: got ready=0 required ready=1");
        end
        s_job_valid = 1'b1;
        s_job_vaddr = va;
        s_job_len   = len;
        @(negedge aclk);
        s_job_valid = 1'b0;
    endtask

    // Expects m_core_ready high for the offered core, so one cycle consumes it.
    task automatic wait_dispatch(input string name, input logic [VB-1:0] va,
                                 input logic [PW-1:0] len, input int core);
        logic [N-1:0] exp_v;
        int n = 0;
        exp_v       = '0;
        exp_v[core] = 1'b1;
        while (m_core_valid == '0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_valid"}, 64'(m_core_valid), 64'(exp_v));
        check({name, "_vaddr"}, 64'(m_core_vaddr), 64'(va));
        check({name, "_len"},   64'(m_core_len),   64'(len));
        @(negedge aclk);
    endtask

    task automatic pulse_done(input int core, input int size);
        core_done_size                = '0;
        core_done_size[core*PW +: PW] = PW'(size);
        core_done                     = '0;
        core_done[core]               = 1'b1;
        @(negedge aclk);
        core_done = '0;
    endtask

    task automatic wait_cpl(input string name, input logic [VB-1:0] va,
                            input logic [PW-1:0] size, input logic last, input int hold);
        int n = 0;
        while (!m_cpl_valid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_valid"}, 64'(m_cpl_valid), 64'd1);
        check({name, "_vaddr"}, 64'(m_cpl_vaddr), 64'(va));
        check({name, "_size"},  64'(m_cpl_size),  64'(size));
        check({name, "_last"},  64'(m_cpl_last),  64'(last));
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            check({name, "_hold"}, {15'd0, m_cpl_valid, m_cpl_vaddr},
                  {15'd0, 1'b1, va});
            check({name, "_hold_size"}, 64'(m_cpl_size), 64'(size));
        end
        m_cpl_ready = 1'b1;
        @(negedge aclk);
        m_cpl_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] seen;

        disp_tab[0] = '{48'h1000, 14'd8192, 0};
        disp_tab[1] = '{48'h3000, 14'd8192, 1};
        disp_tab[2] = '{48'h5000, 14'd3616, 2};
        cpl_tab[0]  = '{0,  200, 48'h1000, 14'd200, 1'b0};
        cpl_tab[1]  = '{1,  300, 48'h3000, 14'd300, 1'b0};
        cpl_tab[2]  = '{-1, 0,   48'h5000, 14'd100, 1'b1};

        // Three-page job with a backpressured first dispatch.
        do_reset();
        send_job(48'h1000, 32'd20000);
        check("accept_ready_low", 64'(s_job_ready), 64'd0);
        check("first_valid", 64'(m_core_valid), 64'd1);
        repeat (2) @(negedge aclk);
        check("hold_core_valid", 64'(m_core_valid), 64'd1);
        check("hold_core_vaddr", 64'(m_core_vaddr), 64'h1000);
        m_core_ready = '1;
        for (int i = 0; i < 3; i++)
            wait_dispatch($sformatf("page%0d", i), disp_tab[i].vaddr,
                          disp_tab[i].len, disp_tab[i].core);
        check("job_done_ready", 64'(s_job_ready), 64'd1);
        check("job_done_quiet", 64'(m_core_valid), 64'd0);
`ifdef COMP_SCHED_STATS_EN
        check("stat_pages", 64'(stat_pages), 64'd3);
`else
        check("stat_pages", 64'(stat_pages), 64'd0);
`endif

        // Out-of-order done pulses still complete in dispatch order.
        pulse_done(2, 100);
        repeat (3) @(negedge aclk);
        check("cpl_blocked_by_head", 64'(m_cpl_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (cpl_tab[i].pre_core >= 0) pulse_done(cpl_tab[i].pre_core, cpl_tab[i].pre_size);
            wait_cpl($sformatf("cpl%0d", i), cpl_tab[i].vaddr, cpl_tab[i].size,
                     cpl_tab[i].last, (i == 0) ? 2 : 0);
        end
        repeat (2) @(negedge aclk);
        check("cpl_drained", 64'(m_cpl_valid), 64'd0);
`ifdef COMP_SCHED_STATS_EN
        check("stat_bytes", 64'(stat_bytes_out), 64'd600);
`else
        check("stat_bytes", 64'(stat_bytes_out), 64'd0);
`endif

        // Seven pages: six cores fill, seventh waits for core0 to free up.
        do_reset();
        m_core_ready = '1;
        send_job(48'h0, 32'd57344);
        for (int i = 0; i < 6; i++)
            wait_dispatch($sformatf("fill%0d", i), 48'(i * 8192), 14'd8192, i);
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            seen |= m_core_valid;
            @(negedge aclk);
        end
        check("stall_no_valid", 64'(seen), 64'd0);
        pulse_done(0, 50);
        wait_cpl("fill_cpl0", 48'h0, 14'd50, 1'b0, 0);
        check("redispatch_valid", 64'(m_core_valid), 64'd1);
        check("redispatch_vaddr", 64'(m_core_vaddr), 64'hC000);
        check("redispatch_len",   64'(m_core_len),   64'd8192);
        @(negedge aclk);
        check("seven_done_ready", 64'(s_job_ready), 64'd1);

        // Zero-length job is accepted and dropped; stray done on idle core ignored.
        do_reset();
        send_job(48'h8000, 32'd0);
        check("zero_len_ready", 64'(s_job_ready), 64'd1);
        pulse_done(4, 999);
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            seen |= m_core_valid;
            seen[0] |= m_cpl_valid;
            @(negedge aclk);
        end
        check("zero_len_quiet", 64'(seen), 64'd0);

        // Reset with three pages outstanding, then a fresh job starts at core0.
        do_reset();
        m_core_ready = '1;
        send_job(48'h20000, 32'd24576);
        for (int i = 0; i < 3; i++)
            wait_dispatch($sformatf("pre%0d", i), 48'h20000 + 48'(i * 8192), 14'd8192, i);
        pulse_done(0, 11);
        @(negedge aclk);
        check("pre_reset_cpl_valid", 64'(m_cpl_valid), 64'd1);
        do_reset();
        m_core_ready = '1;
        send_job(48'h40000, 32'd100);
        wait_dispatch("post_rst", 48'h40000, 14'd100, 0);
        pulse_done(0, 7);
        wait_cpl("post_rst_cpl", 48'h40000, 14'd7, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comp_scheduler.md
COMP_SCHEDULER -- requirements
Module: comp_scheduler

Interface
REQ-001 SHALL have parameter N_CORES, default COMP_CORES (6): number of compression cores scheduled.
REQ-002 SHALL have parameter PAGE_BYTES, default PAGE_SIZE (8192): maximum bytes per page job.
REQ-003 SHALL have port aclk, input, 1: single clock for all logic.
REQ-004 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports s_job_valid/s_job_ready, in/out, 1 each: job request handshake.
REQ-006 SHALL have ports s_job_vaddr, in, VADDR_BITS (vaddr_t) and s_job_len, in, 32: job start address and byte length.
REQ-007 SHALL have ports m_core_valid/m_core_ready, out/in, N_CORES each: per-core dispatch handshake.
REQ-008 SHALL have ports m_core_vaddr, out, VADDR_BITS and m_core_len, out, PAGE_SIZE_WIDTH (page_size_t): page shared by all cores.
REQ-009 SHALL have ports core_done, in, N_CORES and core_done_size, in, N_CORES*PAGE_SIZE_WIDTH: per-core done pulse and compressed size.
REQ-010 SHALL have ports m_cpl_valid/m_cpl_ready, out/in, 1 each: completion handshake.
REQ-011 SHALL have ports m_cpl_vaddr, out, VADDR_BITS, m_cpl_size, out, PAGE_SIZE_WIDTH and m_cpl_last, out, 1: completion page address, compressed size, last page of job.
REQ-012 SHALL have ports stat_pages, out, 32 and stat_bytes_out, out, 48: statistics.

Function
REQ-013 SHALL use FSM IDLE/ISSUE; s_job_ready=1 only in IDLE.
REQ-014 SHALL, on s_job_valid&&s_job_ready with s_job_len>0, latch vaddr and remaining length and enter ISSUE next cycle; with s_job_len=0, accept and drop the job, stay IDLE, and produce no completion.
REQ-015 SHALL, in ISSUE, present page length = min(remaining, PAGE_BYTES) and current vaddr on m_core_vaddr/m_core_len.
REQ-016 SHALL select the first idle core at or after round-robin pointer rr (wrapping mod N_CORES) and assert m_core_valid for that core only, one-hot, registered, no earlier than the cycle after job accept.
REQ-017 SHALL hold m_core_valid and page fields stable until m_core_ready for that core is high.
REQ-018 SHALL assert all m_core_valid=0 while no core is idle; issue SHALL resume on the first cycle a core becomes idle.
REQ-019 SHALL, on a dispatch handshake to core c: mark c busy; push {c, vaddr, last} into an order FIFO of depth N_CORES; add page length to vaddr; subtract it from remaining; set rr=(c+1) mod N_CORES.
REQ-020 SHALL set last=1 when remaining equals page length, then return to IDLE.
REQ-021 SHALL, on core_done[i] with core i busy and result_valid[i]=0, latch core_done_size slice i and set result_valid[i]; core_done on any other core SHALL be ignored.
REQ-022 SHALL assert m_cpl_valid, registered, when FIFO non-empty and result_valid[head core]=1, with vaddr/last from the FIFO head and size from that core's result register.
REQ-023 SHALL deliver completions strictly in dispatch order regardless of core_done order.
REQ-024 SHALL, on m_cpl handshake, pop the FIFO, clear result_valid and busy for that core; that core SHALL be dispatchable the following cycle.
REQ-025 SHALL hold m_cpl fields stable while m_cpl_valid&&!m_cpl_ready.

Reset
REQ-026 SHALL, on areset (including mid-job), enter IDLE, clear busy, result_valid, FIFO, rr=0, stats=0.
REQ-027 SHALL drive reset values s_job_ready=0 during reset and 1 the cycle after release, m_core_valid=0, m_cpl_valid=0, m_cpl_last=0, with data outputs 0.

Configuration
REQ-028 SHALL, with COMP_SCHED_STATS_EN defined, increment stat_pages per dispatch and add m_cpl_size to stat_bytes_out per completion handshake, both wrapping.
REQ-029 SHALL, without COMP_SCHED_STATS_EN, tie stat_pages and stat_bytes_out to 0 with no counter logic.

Verification
REQ-030 SHALL verify: job vaddr=0x1000, len=20000 -> pages {0x1000,8192,core0},{0x3000,8192,core1},{0x5000,3616,core2}, last on third.
REQ-031 SHALL verify: above job, core_done order 2,0,1 with sizes 100,200,300 -> completions in order sizes 200,300,100.
REQ-032 SHALL verify: 7-page job with no completions consumed -> 6 dispatches to cores 0-5, 7th stalls, then dispatches to core0 one cycle after core0's completion handshake.
REQ-033 SHALL verify: len=0 job -> s_job_ready pulses, no m_core_valid, no m_cpl_valid.
REQ-034 SHALL verify: areset asserted with 3 pages outstanding -> all valids 0, next job dispatches to core0.
REQ-035 SHALL verify: with COMP_SCHED_STATS_EN, REQ-030/031 run -> stat_pages=3, stat_bytes_out=600; without it, both 0.
